// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg
//  Shared definitions for the instruction-fetch front end.
//  - XLEN, RESET_PC, PC_INC : default datapath width, reset PC and PC step.
//  - fetch_state_t          : fetch controller states.
//      REQ  : request is issued this cycle.
//      WAIT : waiting for the read data.
//      HOLD : instruction is held for decode.
package pc_fetch_ctrl_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'h0000_0004;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if
//  Bus bundle between the fetch controller, instruction memory and decode.
//  - imem_req/imem_addr   : fetch request (controller -> memory)
//  - imem_ack/imem_rdata  : read response (memory -> controller)
//  - if_valid/if_pc/if_instr : fetched instruction (controller -> decode)
//  - if_ready             : decode accepts (decode -> controller)
//  Modports: master = fetch controller, slave = memory/decode side.
interface pc_fetch_ctrl_if #(
    parameter int XLEN = pc_fetch_ctrl_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//  Program-counter register and single-outstanding instruction-fetch controller.
//  The PC adder lives outside this block: pc_cur/pc_inc go out to it and its
//  sum comes back on pc_seq as the sequential next PC.
//  Ports:
//   clk        : clock, all state updates on posedge
//   rst        : synchronous active-high reset
//   pc_cur     : current PC (adder operand a)
//   pc_inc     : constant PC_INC (adder operand b)
//   pc_seq     : adder result, pc_cur + PC_INC modulo 2^XLEN
//   br_taken   : single-cycle redirect request
//   br_target  : redirect target, low two bits forced to zero
//   bus        : memory request/response and decode valid/ready (master)
module pc_fetch_ctrl #(
    parameter int              XLEN     = pc_fetch_ctrl_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = pc_fetch_ctrl_pkg::RESET_PC,
    parameter logic [XLEN-1:0] PC_INC   = pc_fetch_ctrl_pkg::PC_INC
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [XLEN-1:0]       pc_cur,
    output logic [XLEN-1:0]       pc_inc,
    input  logic [XLEN-1:0]       pc_seq,
    input  logic                  br_taken,
    input  logic [XLEN-1:0]       br_target,
    pc_fetch_ctrl_if.master       bus
);
    import pc_fetch_ctrl_pkg::*;

    // Instructions are word aligned; the redirect target's low bits are dropped.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic            squash_q;
    logic            if_valid_q;
    logic [XLEN-1:0] if_pc_q;
    logic [XLEN-1:0] if_instr_q;

    assign pc_cur        = pc_q;
    assign pc_inc        = PC_INC;
    // The memory takes the request in the cycle it is raised, so req is
    // simply "state is REQ" and the address is the live PC.
    assign bus.imem_req  = (state_q == REQ);
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            squash_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            case (state_q)
                REQ: begin
                    // A redirect here means the request just issued is for
                    // the old PC; its response must be thrown away.
                    squash_q <= br_taken;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        squash_q <= 1'b0;
                        if (squash_q || br_taken) begin
                            state_q <= REQ;
                        end else begin
                            if_pc_q    <= pc_q;
                            if_instr_q <= bus.imem_rdata;
                            if_valid_q <= 1'b1;
                            pc_q       <= pc_seq;
                            state_q    <= HOLD;
                        end
                    end else if (br_taken) begin
                        squash_q <= 1'b1;
                    end
                end
                HOLD: begin
                    // Redirect drops the held word; a plain accept retires it.
                    // Both lead back to REQ with if_valid cleared.
                    if (br_taken || bus.if_ready) begin
                        if_valid_q <= 1'b0;
                        state_q    <= REQ;
                    end
                end
                default: begin
                    state_q <= REQ;
                end
            endcase

            // Redirect target overrides any sequential PC update above.
            if (br_taken) begin
                pc_q <= br_target & ALIGN_MASK;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl
//  Directed bench for pc_fetch_ctrl. Two instances share clock, reset and
//  control: dut_a uses the default RESET_PC, dut_b uses 32'hFFFFFFFC to
//  exercise PC wrap. The bench models the external PC adder and a
//  1-cycle-latency instruction memory.
module tb_pc_fetch_ctrl;
    localparam int XLEN = 32;
    localparam logic [31:0] INSTR_A = 32'h00A0_0093;
    localparam logic [31:0] INSTR_B = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            br_taken = 1'b0;
    logic [XLEN-1:0] br_target = '0;
    logic            if_ready = 1'b0;
    logic            mem_en = 1'b0;
    logic            ack_now = 1'b0;
    logic [XLEN-1:0] rdata = '0;
    logic            ack_a = 1'b0;
    logic            ack_b = 1'b0;

    logic [XLEN-1:0] pc_cur_a, pc_inc_a, pc_seq_a;
    logic [XLEN-1:0] pc_cur_b, pc_inc_b, pc_seq_b;

    int checks = 0;
    int passed = 0;

    pc_fetch_ctrl_if #(.XLEN(XLEN)) if_a ();
    pc_fetch_ctrl_if #(.XLEN(XLEN)) if_b ();

    // External PC adder model, wraps modulo 2^32.
    assign pc_seq_a = pc_cur_a + pc_inc_a;
    assign pc_seq_b = pc_cur_b + pc_inc_b;

    assign if_a.imem_ack   = ack_a;
    assign if_a.imem_rdata = rdata;
    assign if_a.if_ready   = if_ready;
    assign if_b.imem_ack   = ack_b;
    assign if_b.imem_rdata = rdata;
    assign if_b.if_ready   = if_ready;

    pc_fetch_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .PC_INC(32'h0000_0004)) dut_a (
        .clk(clk), .rst(rst), .pc_cur(pc_cur_a), .pc_inc(pc_inc_a), .pc_seq(pc_seq_a),
        .br_taken(br_taken), .br_target(br_target), .bus(if_a)
    );

    pc_fetch_ctrl #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFFC), .PC_INC(32'h0000_0004)) dut_b (
        .clk(clk), .rst(rst), .pc_cur(pc_cur_b), .pc_inc(pc_inc_b), .pc_seq(pc_seq_b),
        .br_taken(br_taken), .br_target(br_target), .bus(if_b)
    );

    always #5 clk = ~clk;

    // One clock cycle. Memory acks one cycle after a request (when mem_en),
    // or when ack_now forces one. br_taken and ack_now are single-cycle pulses.
    task automatic tick();
        logic ra, rb;
        ra = if_a.imem_req;
        rb = if_b.imem_req;
        @(posedge clk);
        #1;
        ack_a    = (mem_en && ra) || ack_now;
        ack_b    = (mem_en && rb) || ack_now;
        ack_now  = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic test_reset();
        mem_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_a.if_valid !== 1'b0) $display("FAIL reset_if_valid[%0d]: got %b want 0", i, if_a.if_valid); else passed++;
        end
        rst = 1'b0;
        checks++; if (if_a.imem_req !== 1'b1) $display("FAIL reset_req: got %b want 1", if_a.imem_req); else passed++;
        checks++; if (if_a.imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", if_a.imem_addr); else passed++;
        checks++; if (if_a.if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h want 00000000", if_a.if_pc); else passed++;
        checks++; if (if_a.if_instr !== 32'h0) $display("FAIL reset_if_instr: got %h want 00000000", if_a.if_instr); else passed++;
        $display("reset released: req=%b addr=%h", if_a.imem_req, if_a.imem_addr);
    endtask

    task automatic test_stream();
        mem_en = 1'b1;
        rdata = INSTR_A;
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            checks++; if (if_a.if_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", k, if_a.if_valid); else passed++;
            checks++; if (if_a.if_pc !== 32'(4 * k)) $display("FAIL stream_pc[%0d]: got %h want %h", k, if_a.if_pc, 32'(4 * k)); else passed++;
            checks++; if (if_a.if_instr !== INSTR_A) $display("FAIL stream_instr[%0d]: got %h want %h", k, if_a.if_instr, INSTR_A); else passed++;
            $display("fetch: pc=%h instr=%h", if_a.if_pc, if_a.if_instr);
            tick();
            checks++; if (if_a.if_valid !== 1'b0 || if_a.imem_req !== 1'b1) $display("FAIL stream_next_req[%0d]: got valid=%b req=%b want valid=0 req=1", k, if_a.if_valid, if_a.imem_req); else passed++;
        end
    endtask

    task automatic test_hold();
        if_ready = 1'b0;
        tick();
        tick();
        rdata = INSTR_B;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (if_a.if_valid !== 1'b1 || if_a.if_pc !== 32'hC || if_a.if_instr !== INSTR_A || if_a.imem_req !== 1'b0)
                $display("FAIL hold_stable[%0d]: got valid=%b pc=%h instr=%h req=%b want valid=1 pc=0000000c instr=%h req=0",
                         i, if_a.if_valid, if_a.if_pc, if_a.if_instr, if_a.imem_req, INSTR_A);
            else passed++;
        end
        $display("hold: pc=%h instr=%h held 5 cycles", if_a.if_pc, if_a.if_instr);
        if_ready = 1'b1;
        tick();
        checks++; if (if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h10) $display("FAIL hold_release_req: got req=%b addr=%h want req=1 addr=00000010", if_a.imem_req, if_a.imem_addr); else passed++;
    endtask

    task automatic test_branch_wait();
        rdata = INSTR_A;
        mem_en = 1'b0;
        tick();
        br_taken = 1'b1;
        br_target = 32'h0000_0103;
        tick();
        checks++; if (pc_cur_a !== 32'h100) $display("FAIL br_wait_pc: got %h want 00000100", pc_cur_a); else passed++;
        ack_now = 1'b1;
        tick();
        tick();
        checks++; if (if_a.if_valid !== 1'b0) $display("FAIL br_wait_squash: got valid=%b want 0", if_a.if_valid); else passed++;
        checks++; if (if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h100) $display("FAIL br_wait_req: got req=%b addr=%h want req=1 addr=00000100", if_a.imem_req, if_a.imem_addr); else passed++;
        mem_en = 1'b1;
        tick();
        tick();
        checks++; if (if_a.if_valid !== 1'b1 || if_a.if_pc !== 32'h100) $display("FAIL br_wait_fetch: got valid=%b pc=%h want valid=1 pc=00000100", if_a.if_valid, if_a.if_pc); else passed++;
        $display("fetch: pc=%h instr=%h", if_a.if_pc, if_a.if_instr);
        tick();
        checks++; if (if_a.imem_addr !== 32'h104) $display("FAIL br_wait_seq: got addr=%h want 00000104", if_a.imem_addr); else passed++;
    endtask

    task automatic test_branch_hold();
        if_ready = 1'b0;
        tick();
        tick();
        checks++; if (if_a.if_valid !== 1'b1 || if_a.if_pc !== 32'h104) $display("FAIL br_hold_pre: got valid=%b pc=%h want valid=1 pc=00000104", if_a.if_valid, if_a.if_pc); else passed++;
        if_ready = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h0000_0200;
        tick();
        checks++; if (if_a.if_valid !== 1'b0 || if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h200)
            $display("FAIL br_hold_redirect: got valid=%b req=%b addr=%h want valid=0 req=1 addr=00000200", if_a.if_valid, if_a.imem_req, if_a.imem_addr);
        else passed++;
    endtask

    task automatic test_branch_req();
        br_taken = 1'b1;
        br_target = 32'h0000_0302;
        tick();
        tick();
        checks++; if (if_a.if_valid !== 1'b0 || if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h300)
            $display("FAIL br_req_squash: got valid=%b req=%b addr=%h want valid=0 req=1 addr=00000300", if_a.if_valid, if_a.imem_req, if_a.imem_addr);
        else passed++;
        tick();
        tick();
        checks++; if (if_a.if_valid !== 1'b1 || if_a.if_pc !== 32'h300) $display("FAIL br_req_fetch: got valid=%b pc=%h want valid=1 pc=00000300", if_a.if_valid, if_a.if_pc); else passed++;
        $display("fetch: pc=%h instr=%h", if_a.if_pc, if_a.if_instr);
        tick();
    endtask

    task automatic test_wrap();
        mem_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_en = 1'b1;
        if_ready = 1'b1;
        checks++; if (if_b.imem_req !== 1'b1 || if_b.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_first_req: got req=%b addr=%h want req=1 addr=fffffffc", if_b.imem_req, if_b.imem_addr); else passed++;
        tick();
        tick();
        checks++; if (if_b.if_valid !== 1'b1 || if_b.if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_first_pc: got valid=%b pc=%h want valid=1 pc=fffffffc", if_b.if_valid, if_b.if_pc); else passed++;
        $display("fetch(b): pc=%h instr=%h", if_b.if_pc, if_b.if_instr);
        tick();
        checks++; if (if_b.imem_req !== 1'b1 || if_b.imem_addr !== 32'h0) $display("FAIL wrap_second_req: got req=%b addr=%h want req=1 addr=00000000", if_b.imem_req, if_b.imem_addr); else passed++;
    endtask

    task automatic test_reset_in_wait();
        mem_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (if_a.if_valid !== 1'b0) $display("FAIL rst_wait_valid: got %b want 0", if_a.if_valid); else passed++;
        checks++; if (if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h0) $display("FAIL rst_wait_req: got req=%b addr=%h want req=1 addr=00000000", if_a.imem_req, if_a.imem_addr); else passed++;
        checks++; if (if_b.imem_addr !== 32'hFFFF_FFFC) $display("FAIL rst_wait_req_b: got addr=%h want fffffffc", if_b.imem_addr); else passed++;
        tick();
        checks++; if (if_a.if_valid !== 1'b0) $display("FAIL rst_wait_after: got %b want 0", if_a.if_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_branch_wait();
        test_branch_hold();
        test_branch_req();
        test_wrap();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
